// File: rtl/btn_event_pkg.sv
// Shared types for the button event controller: event type codes
// and per-button FSM state encoding.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

  localparam logic [1:0] EVT_SHORT   = 2'b00;
  localparam logic [1:0] EVT_LONG    = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;
  localparam logic [1:0] EVT_RELEASE = 2'b11;

endpackage

// File: rtl/btn_event_fifo.sv
// Event queue: DEPTH x W ring buffer, push/pop, full/empty.
// Ports: clk, reset (sync, active-high), i_push/i_wdata, i_pop, o_rdata (head), o_full, o_empty.
module btn_event_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A full queue still accepts a write when the head leaves this cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_rdata = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller: per-button SHORT/LONG/RELEASE detection,
// one-entry pending slots, fixed-priority arbiter into an event FIFO.
// Ports: clk, reset (sync, active-high), btn_lvl, evt_valid/evt_ready/evt_data
// ({type, btn_id}), ovf (sticky drop flag), ovf_clr.
// Define BTN_AUTOREPEAT_EN to emit REPEAT events while a button stays in LONG.
module btn_event_ctrl
  import btn_event_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_BTN-1:0]           btn_lvl,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [2+$clog2(NUM_BTN)-1:0] evt_data,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int ID_W = $clog2(NUM_BTN);
  localparam int DW   = 2 + ID_W;
  localparam int CW   = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_C = CW'(REPEAT_CYCLES);
`endif

  if (NUM_BTN < 2 || NUM_BTN > 8) begin : g_chk_nb
    $error("NUM_BTN out of range");
  end
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_chk_cyc
    $error("LONG_CYCLES/REPEAT_CYCLES below 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fd
    $error("FIFO_DEPTH not a power of two >= 2");
  end

  btn_state_e               r_state [NUM_BTN];
  btn_state_e               w_nstate [NUM_BTN];
  logic [CW-1:0]            r_cnt [NUM_BTN];
  logic [CW-1:0]            w_ncnt [NUM_BTN];
  logic [CW-1:0]            w_inc [NUM_BTN];
  logic [NUM_BTN-1:0]       r_prev;
  logic [NUM_BTN-1:0]       w_evt_v;
  logic [NUM_BTN-1:0][1:0]  w_evt_t;

  logic [NUM_BTN-1:0]       r_pend_v;
  logic [NUM_BTN-1:0][1:0]  r_pend_t;
  logic [NUM_BTN-1:0]       w_take;
  logic [NUM_BTN-1:0]       w_drop_v;
  logic                     w_any;
  logic [ID_W-1:0]          w_sel;
  logic                     r_ovf;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [DW-1:0]            w_pdata;
  logic [DW-1:0]            w_rdata;

  // Per-button FSM: next state, counter and detected event.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_evt_v  = '0;
    w_evt_t  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_inc[i] = (r_cnt[i] == '1) ? r_cnt[i] : r_cnt[i] + 1'b1;
      case (r_state[i])
        ST_IDLE: begin
          if (btn_lvl[i] && !r_prev[i]) begin
            w_nstate[i] = ST_HELD;
            w_ncnt[i]   = CW'(1);
          end
        end
        ST_HELD: begin
          if (!btn_lvl[i]) begin
            w_nstate[i] = ST_IDLE;
            w_ncnt[i]   = '0;
            w_evt_v[i]  = 1'b1;
            w_evt_t[i]  = EVT_SHORT;
          end else if (w_inc[i] == LONG_C) begin
            w_nstate[i] = ST_LONG;
            w_evt_v[i]  = 1'b1;
            w_evt_t[i]  = EVT_LONG;
`ifdef BTN_AUTOREPEAT_EN
            w_ncnt[i]   = CW'(1);
`else
            w_ncnt[i]   = w_inc[i];
`endif
          end else begin
            w_ncnt[i]   = w_inc[i];
          end
        end
        ST_LONG: begin
          if (!btn_lvl[i]) begin
            w_nstate[i] = ST_IDLE;
            w_ncnt[i]   = '0;
            w_evt_v[i]  = 1'b1;
            w_evt_t[i]  = EVT_RELEASE;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (r_cnt[i] == REP_C) begin
            w_ncnt[i]   = CW'(1);
            w_evt_v[i]  = 1'b1;
            w_evt_t[i]  = EVT_REPEAT;
          end else begin
            w_ncnt[i]   = w_inc[i];
          end
`endif
        end
        default: begin
          w_nstate[i] = ST_IDLE;
          w_ncnt[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_prev <= btn_lvl;
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Lowest index wins: descending scan leaves the lowest set bit selected.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend_v[i]) begin
        w_any = 1'b1;
        w_sel = ID_W'(i);
      end
    end
  end

  assign w_pop   = ~w_empty & evt_ready;
  assign w_push  = w_any & (~w_full | w_pop);
  assign w_pdata = {r_pend_t[w_sel], w_sel};

  // A slot being drained this cycle can take a new event without loss.
  always_comb begin
    w_take   = '0;
    w_drop_v = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_take[i]   = w_push & (w_sel == ID_W'(i));
      w_drop_v[i] = w_evt_v[i] & r_pend_v[i] & ~w_take[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_v <= '0;
      r_pend_t <= '0;
      r_ovf    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_evt_v[i] && !w_drop_v[i]) begin
          r_pend_v[i] <= 1'b1;
          r_pend_t[i] <= w_evt_t[i];
        end else if (w_take[i]) begin
          r_pend_v[i] <= 1'b0;
        end
      end
      if (ovf_clr)        r_ovf <= 1'b0;
      else if (|w_drop_v) r_ovf <= 1'b1;
    end
  end

  btn_event_fifo #(
    .W     (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_pdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid = ~w_empty;
  assign evt_data  = w_empty ? '0 : w_rdata;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl (NUM_BTN=4, LONG=8, REPEAT=4, DEPTH=4).
// Cycle table for short presses plus directed long-press, overflow and reset sequences.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_data;
  logic       ovf;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  btn_event_ctrl #(
    .NUM_BTN       (4),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_lvl   (btn_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic [3:0] btn;
    logic       ev;
    logic [3:0] ed;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn_lvl = 4'(1 << b);
    tick();
    btn_lvl = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] drain [5];
    // Short press btn2 (3 samples), event 2 cycles after fall.
    tbl[0]  = '{4'b0000, 1'b0, 4'h0};
    tbl[1]  = '{4'b0100, 1'b0, 4'h0};
    tbl[2]  = '{4'b0100, 1'b0, 4'h0};
    tbl[3]  = '{4'b0100, 1'b0, 4'h0};
    tbl[4]  = '{4'b0000, 1'b0, 4'h0};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0010};
    tbl[6]  = '{4'b0000, 1'b0, 4'h0};
    // btn0 and btn3 fall together: 00_00 then 00_11.
    tbl[7]  = '{4'b1001, 1'b0, 4'h0};
    tbl[8]  = '{4'b1001, 1'b0, 4'h0};
    tbl[9]  = '{4'b0000, 1'b0, 4'h0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 4'b0011};
    tbl[12] = '{4'b0000, 1'b0, 4'h0};
    // btn1 held 7 samples: one short of LONG, so SHORT.
    for (int i = 13; i <= 19; i++) tbl[i] = '{4'b0010, 1'b0, 4'h0};
    tbl[20] = '{4'b0000, 1'b0, 4'h0};
    tbl[21] = '{4'b0000, 1'b1, 4'b0001};
    tbl[22] = '{4'b0000, 1'b0, 4'h0};

    reset     = 1'b1;
    btn_lvl   = 4'b0000;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick();
    tick();
    chk("reset valid", 8'(evt_valid), 8'h0);
    chk("reset data", 8'(evt_data), 8'h0);
    chk("reset ovf", 8'(ovf), 8'h0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      btn_lvl = tbl[i].btn;
      tick();
      chk($sformatf("vec%0d valid", i), 8'(evt_valid), 8'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("vec%0d data", i), 8'(evt_data), 8'(tbl[i].ed));
      chk($sformatf("vec%0d ovf", i), 8'(ovf), 8'h0);
    end

    // btn1 held 20 samples, then released.
    for (int h = 1; h <= 23; h++) begin
      logic       ev;
      logic [3:0] ed;
      btn_lvl = (h <= 20) ? 4'b0010 : 4'b0000;
      tick();
      ev = 1'b0;
      ed = 4'h0;
      if (h == 9) begin ev = 1'b1; ed = 4'b0101; end
      if (h == 22) begin ev = 1'b1; ed = 4'b1101; end
`ifdef BTN_AUTOREPEAT_EN
      if (h == 13 || h == 17 || h == 21) begin ev = 1'b1; ed = 4'b1001; end
`endif
      chk($sformatf("long h%0d valid", h), 8'(evt_valid), 8'(ev));
      if (ev) chk($sformatf("long h%0d data", h), 8'(evt_data), 8'(ed));
    end

    // Back-pressure: 4 queued, 5th pending, drops set ovf.
    evt_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      press(b);
      chk($sformatf("bp q%0d valid", b), 8'(evt_valid), 8'h1);
      chk($sformatf("bp q%0d head", b), 8'(evt_data), 8'h0);
    end
    press(0);
    chk("bp 5th ovf", 8'(ovf), 8'h0);
    chk("bp 5th head", 8'(evt_data), 8'h0);
    btn_lvl = 4'b0001;
    tick();
    btn_lvl = 4'b0000;
    tick();
    chk("bp 6th ovf", 8'(ovf), 8'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf clr", 8'(ovf), 8'h0);
    btn_lvl = 4'b0001;
    tick();
    btn_lvl = 4'b0000;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf clr wins", 8'(ovf), 8'h0);
    btn_lvl = 4'b0001;
    tick();
    btn_lvl = 4'b0000;
    tick();
    chk("ovf reassert", 8'(ovf), 8'h1);

    drain[0] = 4'b0000;
    drain[1] = 4'b0001;
    drain[2] = 4'b0010;
    drain[3] = 4'b0011;
    drain[4] = 4'b0000;
    evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain%0d valid", k), 8'(evt_valid), 8'h1);
      chk($sformatf("drain%0d data", k), 8'(evt_data), 8'(drain[k]));
      tick();
    end
    chk("drain empty", 8'(evt_valid), 8'h0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Reset mid-operation with btn1 in LONG and 2 queued.
    evt_ready = 1'b0;
    press(0);
    press(2);
    btn_lvl = 4'b0010;
    for (int j = 0; j < 8; j++) tick();
    chk("pre-rst valid", 8'(evt_valid), 8'h1);
    chk("pre-rst head", 8'(evt_data), 8'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst valid", 8'(evt_valid), 8'h0);
    chk("rst data", 8'(evt_data), 8'h0);
    chk("rst ovf", 8'(ovf), 8'h0);
    evt_ready = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      tick();
      chk($sformatf("post-rst j%0d valid", j), 8'(evt_valid),
          8'(j == 9));
    end
    chk("post-rst long", 8'(evt_data), 8'b0101);
    btn_lvl = 4'b0000;
    tick();
    tick();
    chk("post-rst rel valid", 8'(evt_valid), 8'h1);
    chk("post-rst rel data", 8'(evt_data), 8'b1101);
    tick();
    chk("final empty", 8'(evt_valid), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of debounced button inputs, range 2..8.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000: consecutive high samples needed for a long press, minimum 2.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000: auto-repeat period after a long press, minimum 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: event queue depth, a power of two of at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port btn_lvl, input, NUM_BTN bits: debounced button levels, already synchronous to clk.
REQ-008 SHALL have port evt_valid, output, 1 bit: event available at evt_data.
REQ-009 SHALL have port evt_ready, input, 1 bit: consumer accepts; transfer occurs when evt_valid and evt_ready are both high.
REQ-010 SHALL have port evt_data, output, 2+ID_W bits, where ID_W = $clog2(NUM_BTN): {type[1:0], btn_id}.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, set when an event is dropped.
REQ-012 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-013 SHALL give each button an FSM with states IDLE, HELD, LONG; prev-level register; saturating hold counter of $clog2(LONG_CYCLES+1) bits.
REQ-014 SHALL move IDLE->HELD on a sampled rising edge of btn_lvl[i], loading the counter with 1.
REQ-015 SHALL increment the counter each cycle in HELD while the button is high, and enter LONG and generate event LONG (01) on the edge where the count reaches LONG_CYCLES.
REQ-016 SHALL generate SHORT (00) on a falling edge in HELD, then go to IDLE.
REQ-017 SHALL generate RELEASE (11) on a falling edge in LONG, then go to IDLE.
REQ-018 SHALL place each generated event into a per-button one-entry pending register on the same edge it is detected.
REQ-019 SHALL drop a new event if that button's pending register is still occupied, and set ovf.
REQ-020 SHALL run a fixed-priority arbiter (lowest btn index wins) that moves at most one pending event per cycle into the FIFO.
REQ-021 SHALL allow a FIFO write when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-022 SHALL drive evt_valid = FIFO not empty and evt_data = head entry; the output SHALL stay stable while evt_valid is high and evt_ready is low.
REQ-023 SHALL give a latency of 2 cycles (empty FIFO, no contention): level change sampled at edge k -> pending at k -> FIFO write at k+1 -> evt_valid high after k+1.
REQ-024 SHALL hold pending events while the FIFO is full; the FSMs keep running.
REQ-025 SHALL make ovf_clr win over a same-cycle set; ovf SHALL reassert on the next drop.
REQ-026 SHALL use wrapping pointers of $clog2(FIFO_DEPTH) bits plus a count register of $clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-027 SHALL, while reset is high, clear all FSMs to IDLE, all counters, prev registers and pending registers to 0, empty the FIFO, and drive evt_valid=0, evt_data=0, ovf=0.
REQ-028 SHALL discard queued and pending events when reset occurs mid-operation; a button held through reset SHALL be seen as a new rising edge on the first cycle after reset.

Configuration
REQ-029 SHALL, when BTN_AUTOREPEAT_EN is defined, generate REPEAT (10) in LONG every REPEAT_CYCLES cycles while the button is held, using the same counter reloaded to 1 at entry to LONG and after each REPEAT.
REQ-030 SHALL, when BTN_AUTOREPEAT_EN is undefined, leave the counter idle in LONG, never generate type 10, and omit the repeat logic entirely.

Structure
REQ-031 SHALL define the event type constants (EVT_SHORT, EVT_LONG, EVT_REPEAT, EVT_RELEASE) and the FSM state encoding in the shared package btn_event_pkg.
REQ-032 SHALL implement the queue as the sub-module btn_event_fifo (parameterised width and depth, push/pop, full/empty); the arbiter and FSMs SHALL stay in the top.

Verification
REQ-033 SHALL use parameters NUM_BTN=4, LONG_CYCLES=8, REPEAT_CYCLES=4, FIFO_DEPTH=4, with evt_ready=1 unless noted.
REQ-034 SHALL check: btn 2 high for 3 cycles -> one event 00_10, 2 cycles after the falling edge.
REQ-035 SHALL check: btn 1 high for 20 cycles, macro off -> 01_01 after the 8th high sample, 11_01 after the release; macro on -> additionally 10_01 at hold cycles 12, 16 and 20.
REQ-036 SHALL check: btn 0 and btn 3 both fall in the same cycle from HELD -> 00_00, then 00_11 on consecutive cycles.
REQ-037 SHALL check: evt_ready=0, 5 short presses on distinct cycles across buttons -> FIFO holds 4, 5th stays pending and ovf stays 0; a 6th press on the pending button -> ovf=1; raise evt_ready -> 5 events in order.
REQ-038 SHALL check: reset pulsed while btn 1 is in LONG with 2 queued events -> evt_valid=0 the next cycle; btn 1 still high -> new HELD, 01_01 after 8 more cycles.
